boot_host: RTL



---
 rtl/boot_host_pkg.sv | 30 +++
 rtl/boot_rsp_assembler.sv | 71 +++++++
 rtl/uart_core.sv | 153 +++++++++++++++
 rtl/boot_host.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/boot_host_pkg.sv
// boot_host_pkg: shared types and constants for the boot host.
//   dl_state_e       download FSM state encoding
//   BYTES_PER_WORD   bytes per image/response word
//   LAST_BYTE_IDX    index of the final byte within a word
//   DEFAULT_BAUD     UART divisor used when the top is not overridden
//   shift_in_lsb     appends an LSB-first byte to a partially built word
package boot_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SEND  = 3'd3,
      ST_WAIT  = 3'd4,
      ST_TAIL  = 3'd5,
      ST_FIN   = 3'd6
   } dl_state_e;

   localparam int          BYTES_PER_WORD = 4;
   localparam logic [1:0]  LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);
   localparam logic [12:0] DEFAULT_BAUD   = 13'h1b2;

   // Response bytes arrive LSB first, so each new byte enters at the top
   // and the older bytes slide toward bit 0.
   function automatic logic [31:0] shift_in_lsb(input logic [31:0] word,
                                                input logic [7:0]  new_byte);
      return {new_byte, word[31:8]};
   endfunction

endpackage

// File: rtl/boot_rsp_assembler.sv
// boot_rsp_assembler: rebuilds 32-bit response words from LSB-first bytes.
//   clk, rst_n     clock, synchronous active-low reset
//   rx_rdy_i       a UART byte is waiting
//   rx_data_i      the waiting byte
//   rsp_clr_i      drop the partial word and restart at byte 0
//   clr_rx_rdy_o   acknowledge to the UART, same cycle as rx_rdy_i
//   rsp_data_o     last completed word
//   rsp_valid_o    one-cycle pulse when rsp_data_o updates
module boot_rsp_assembler
   import boot_host_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_rdy_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rsp_clr_i,
   output logic        clr_rx_rdy_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_valid_o
);

   logic [1:0]  cnt_q,   cnt_d;
   logic [31:0] shreg_q, shreg_d;
   logic [31:0] data_q,  data_d;
   logic        valid_q, valid_d;
   logic [31:0] merged_s;

   // Byte collection; a clear takes priority and swallows a coincident byte.
   always_comb begin
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      merged_s = shift_in_lsb(shreg_q, rx_data_i);
      if (rsp_clr_i) begin
         cnt_d   = 2'd0;
         shreg_d = 32'h0000_0000;
      end else if (rx_rdy_i) begin
         shreg_d = merged_s;
         if (cnt_q == LAST_BYTE_IDX) begin
            data_d  = merged_s;
            valid_d = 1'b1;
            cnt_d   = 2'd0;
         end else begin
            cnt_d = cnt_q + 2'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Assembler state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= 2'd0;
         shreg_q <= 32'h0000_0000;
         data_q  <= 32'h0000_0000;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign clr_rx_rdy_o = rx_rdy_i;
   assign rsp_data_o   = data_q;
   assign rsp_valid_o  = valid_q;

endmodule

// File: rtl/uart_core.sv
// uart_core: 8N1 UART transmitter and receiver sharing one baud divisor.
//   clk, rst_n     clock, synchronous active-low reset
//   RX / TX        serial in / serial out (idle high)
//   trmt, tx_data  start a transmission of tx_data (ignored while sending)
//   tx_done        one-cycle pulse when the stop bit has been sent
//   rx_rdy         high while a received byte is waiting in rx_data
//   clr_rx_rdy     acknowledges (clears) rx_rdy
module uart_core #(
   parameter logic [12:0] BAUD = 13'h1b2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   output logic       TX,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx_done,
   output logic       rx_rdy,
   input  logic       clr_rx_rdy,
   output logic [7:0] rx_data
);

   logic        tx_busy_q,  tx_busy_d;
   logic [9:0]  tx_shift_q, tx_shift_d;
   logic [12:0] tx_baud_q,  tx_baud_d;
   logic [3:0]  tx_bit_q,   tx_bit_d;
   logic        tx_done_q,  tx_done_d;

   logic        rx_sync1_q, rx_sync2_q;
   logic        rx_busy_q,  rx_busy_d;
   logic [12:0] rx_baud_q,  rx_baud_d;
   logic [3:0]  rx_bit_q,   rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_rdy_q,   rx_rdy_d;

   // Transmit sequencing: start, 8 data bits LSB first, stop.
   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_shift_d = tx_shift_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_done_d  = 1'b0;
      if (tx_busy_q) begin
         if (tx_baud_q == BAUD - 13'd1) begin
            tx_baud_d  = 13'd0;
            // Ones shifted in keep the line idle-high once the frame ends.
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            if (tx_bit_q == 4'd9) begin
               tx_busy_d = 1'b0;
               tx_bit_d  = 4'd0;
               tx_done_d = 1'b1;
            end else begin
               tx_bit_d = tx_bit_q + 4'd1;
            end
         end else begin
            tx_baud_d = tx_baud_q + 13'd1;
         end
      end else if (trmt) begin
         tx_busy_d  = 1'b1;
         tx_shift_d = {1'b1, tx_data, 1'b0};
         tx_baud_d  = 13'd0;
         tx_bit_d   = 4'd0;
      end else begin
         tx_busy_d = 1'b0;
      end
   end

   // Receive sequencing: centre on the start bit, then sample every BAUD.
   always_comb begin
      rx_busy_d  = rx_busy_q;
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      if (clr_rx_rdy) begin
         rx_rdy_d = 1'b0;
      end else begin
         rx_rdy_d = rx_rdy_q;
      end
      if (!rx_busy_q) begin
         if (!rx_sync2_q) begin
            rx_busy_d = 1'b1;
            rx_baud_d = BAUD >> 1;
            rx_bit_d  = 4'd0;
         end else begin
            rx_busy_d = 1'b0;
         end
      end else if (rx_baud_q != 13'd0) begin
         rx_baud_d = rx_baud_q - 13'd1;
      end else begin
         rx_baud_d = BAUD - 13'd1;
         case (rx_bit_q)
            4'd0: begin
               // A start bit that is gone at its centre was a glitch.
               if (rx_sync2_q) begin
                  rx_busy_d = 1'b0;
               end else begin
                  rx_bit_d = 4'd1;
               end
            end
            4'd9: begin
               rx_busy_d = 1'b0;
               rx_bit_d  = 4'd0;
               if (rx_sync2_q) begin
                  rx_rdy_d = 1'b1;
               end else begin
                  rx_rdy_d = rx_rdy_d;
               end
            end
            default: begin
               rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 4'd1;
            end
         endcase
      end
   end

   // UART state registers, RX double-synchronised.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_busy_q  <= 1'b0;
         tx_shift_q <= 10'h3ff;
         tx_baud_q  <= 13'd0;
         tx_bit_q   <= 4'd0;
         tx_done_q  <= 1'b0;
         rx_sync1_q <= 1'b1;
         rx_sync2_q <= 1'b1;
         rx_busy_q  <= 1'b0;
         rx_baud_q  <= 13'd0;
         rx_bit_q   <= 4'd0;
         rx_shift_q <= 8'h00;
         rx_rdy_q   <= 1'b0;
      end else begin
         tx_busy_q  <= tx_busy_d;
         tx_shift_q <= tx_shift_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         tx_done_q  <= tx_done_d;
         rx_sync1_q <= RX;
         rx_sync2_q <= rx_sync1_q;
         rx_busy_q  <= rx_busy_d;
         rx_baud_q  <= rx_baud_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_rdy_q   <= rx_rdy_d;
      end
   end

   assign TX      = tx_shift_q[0];
   assign tx_done = tx_done_q;
   assign rx_rdy  = rx_rdy_q;
   assign rx_data = rx_shift_q;

endmodule

// File: rtl/boot_host.sv
// boot_host: streams an image from local memory to the target over UART
// (MSB byte first) with debug held high, and collects LSB-first responses.
//   clk, rst_n            clock, synchronous active-low reset
//   start, image_len      begin a download of image_len words (when idle)
//   mem_rd, mem_addr      image memory read strobe / word address
//   mem_rdata             read data, valid the cycle after mem_rd
//   debug                 target boot-mode enable
//   TX, RX                UART serial lines
//   busy, done            download in progress / one-cycle completion pulse
//   rsp_data, rsp_valid   last response word / update pulse
//   rsp_clr               restart response byte collection
module boot_host
   import boot_host_pkg::*;
#(
   parameter logic [12:0] BAUD        = DEFAULT_BAUD,
   parameter int          ADDR_W      = 16,
   parameter int          TAIL_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] image_len,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic              debug,
   output logic              TX,
   input  logic              RX,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rsp_data,
   output logic              rsp_valid,
   input  logic              rsp_clr
);

   localparam int                TAIL_W    = $clog2(TAIL_CYCLES) + 1;
   localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_CYCLES - 1);

   dl_state_e           state_q,    state_d;
   logic [ADDR_W-1:0]   len_q,      len_d;
   // One bit wider than the address so a full-range length never wraps.
   logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
   logic [ADDR_W:0]     word_inc_s;
   logic [1:0]          byte_cnt_q, byte_cnt_d;
   logic [31:0]         shreg_q,    shreg_d;
   logic [TAIL_W-1:0]   tail_cnt_q, tail_cnt_d;
   logic                debug_q,    debug_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;
   logic                mem_rd_q,   mem_rd_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                trmt_q,     trmt_d;

   logic                tx_done_s;
   logic                rx_rdy_s;
   logic                clr_rx_rdy_s;
   logic [7:0]          rx_data_s;

   // Download FSM next state plus next values of the registered outputs.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      word_inc_s = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
      byte_cnt_d = byte_cnt_q;
      shreg_d    = shreg_q;
      tail_cnt_d = tail_cnt_q;
      debug_d    = debug_q;
      busy_d     = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (image_len != {ADDR_W{1'b0}}) begin
                  len_d      = image_len;
                  word_cnt_d = {(ADDR_W+1){1'b0}};
                  debug_d    = 1'b1;
                  busy_d     = 1'b1;
                  state_d    = ST_FETCH;
               end else begin
                  state_d = ST_FIN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            shreg_d    = mem_rdata;
            byte_cnt_d = 2'd0;
            state_d    = ST_SEND;
         end
         ST_SEND: state_d = ST_WAIT;
         ST_WAIT: begin
            if (tx_done_s) begin
               shreg_d    = {shreg_q[23:0], 8'h00};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == LAST_BYTE_IDX) begin
                  word_cnt_d = word_inc_s;
                  if (word_inc_s == {1'b0, len_q}) begin
                     tail_cnt_d = {TAIL_W{1'b0}};
                     state_d    = ST_TAIL;
                  end else begin
                     state_d = ST_FETCH;
                  end
               end else begin
                  state_d = ST_SEND;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_TAIL: begin
            // Give the target time to commit its last word before debug falls.
            if (tail_cnt_q == TAIL_LAST) begin
               debug_d = 1'b0;
               state_d = ST_FIN;
            end else begin
               tail_cnt_d = tail_cnt_q + {{(TAIL_W-1){1'b0}}, 1'b1};
            end
         end
         ST_FIN: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      mem_rd_d = (state_d == ST_FETCH);
      if (state_d == ST_FETCH) begin
         mem_addr_d = word_cnt_d[ADDR_W-1:0];
      end else begin
         mem_addr_d = mem_addr_q;
      end
      trmt_d = (state_d == ST_SEND);
      done_d = (state_q == ST_FIN);
   end

   // Download FSM and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= {ADDR_W{1'b0}};
         word_cnt_q <= {(ADDR_W+1){1'b0}};
         byte_cnt_q <= 2'd0;
         shreg_q    <= 32'h0000_0000;
         tail_cnt_q <= {TAIL_W{1'b0}};
         debug_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= {ADDR_W{1'b0}};
         trmt_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shreg_q    <= shreg_d;
         tail_cnt_q <= tail_cnt_d;
         debug_q    <= debug_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         trmt_q     <= trmt_d;
      end
   end

   uart_core #(
      .BAUD(BAUD)
   ) u_uart (
      .clk        (clk),
      .rst_n      (rst_n),
      .RX         (RX),
      .TX         (TX),
      .trmt       (trmt_q),
      .tx_data    (shreg_q[31:24]),
      .tx_done    (tx_done_s),
      .rx_rdy     (rx_rdy_s),
      .clr_rx_rdy (clr_rx_rdy_s),
      .rx_data    (rx_data_s)
   );

   boot_rsp_assembler u_rsp (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_rdy_i     (rx_rdy_s),
      .rx_data_i    (rx_data_s),
      .rsp_clr_i    (rsp_clr),
      .clr_rx_rdy_o (clr_rx_rdy_s),
      .rsp_data_o   (rsp_data),
      .rsp_valid_o  (rsp_valid)
   );

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign debug    = debug_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
